// File: rtl/asmd_collect_pkg.sv
// Shared definitions for the A/E/F result collector: FSM encoding and record layout.
package asmd_collect_pkg;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  // Cycle count sits at the bottom; the other fields are offsets above it.
  localparam int CYC_LSB = 0;
  localparam int A_LSB   = 0;
  localparam int E_BIT   = 4;
  localparam int TO_BIT  = 5;

  function automatic int rec_w(input int cnt_w);
    return cnt_w + 6;
  endfunction

endpackage

// File: rtl/result_fifo.sv
// Synchronous first-word-fall-through FIFO; a push while full only lands if a pop frees a slot.
module result_fifo #(
  parameter int WIDTH = 14,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset_b,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  output logic                     full,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign empty    = (count == '0);
  assign full     = (count == (AW+1)'(DEPTH));
  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | do_pop);
  assign pop_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/asmd_result_collector.sv
// Measures each Start..F-rise run of the A/E/F example and queues {timeout, E, A, cycles} records.
// Optional run timeout is compiled in with `define ASMD_TIMEOUT_EN.
module asmd_result_collector
  import asmd_collect_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int CNT_W       = 8,
  parameter int TIMEOUT_CYC = 200
) (
  input  logic                        clock,
  input  logic                        reset_b,
  input  logic                        Start,
  input  logic [3:0]                  A,
  input  logic                        E,
  input  logic                        F,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [rec_w(CNT_W)-1:0]     out_data,
  output logic [$clog2(DEPTH):0]      fifo_count,
  output logic                        overflow,
  input  logic                        clr_ovf
);
  localparam int RW = rec_w(CNT_W);
`ifdef ASMD_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  state_t           state;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             f_d, f_rise, to_hit, rec_push, drop;
  logic             fifo_full, fifo_empty;
  logic [RW-1:0]    rec;

  // Recorded length counts the edge that samples the completion, hence the +1.
  assign cnt_nxt  = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + 1'b1;
  assign f_rise   = F & ~f_d;
  assign to_hit   = TO_EN && (int'(cnt_nxt) == TIMEOUT_CYC - 1);
  assign rec_push = (state == RUN) && !Start && (f_rise || to_hit);
  assign drop     = rec_push & fifo_full & ~out_ready;
  assign out_valid = ~fifo_empty;

  always_comb begin
    rec = '0;
    rec[CYC_LSB +: CNT_W]   = cnt_nxt;
    rec[CNT_W+A_LSB +: 4]   = A;
    rec[CNT_W+E_BIT]        = E;
    rec[CNT_W+TO_BIT]       = to_hit;
  end

  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      state    <= IDLE;
      cnt      <= '0;
      f_d      <= 1'b0;
      overflow <= 1'b0;
    end else begin
      f_d <= F;
      case (state)
        IDLE: if (Start) begin
          state <= RUN;
          cnt   <= '0;
        end
        RUN: begin
          if (Start)         cnt   <= '0;
          else if (rec_push) state <= IDLE;
          else               cnt   <= cnt_nxt;
        end
        default: state <= IDLE;
      endcase
      if (drop)         overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
    end
  end

  result_fifo #(.WIDTH(RW), .DEPTH(DEPTH)) u_fifo (
    .clock     (clock),
    .reset_b   (reset_b),
    .push      (rec_push),
    .push_data (rec),
    .full      (fifo_full),
    .pop       (out_ready),
    .pop_data  (out_data),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_asmd_result_collector.sv
// Scoreboard bench for asmd_result_collector: directed runs queue expected records, a monitor checks pops.
module tb_asmd_result_collector;
  logic        clock = 1'b0;
  logic        reset_b = 1'b0;
  logic        Start = 1'b0, E = 1'b0, F = 1'b0;
  logic [3:0]  A = 4'd0;
  logic        out_ready = 1'b0, clr_ovf = 1'b0;
  logic        out_valid, overflow;
  logic [13:0] out_data;
  logic [2:0]  fifo_count;

  int n_chk = 0;
  int n_fail = 0;
  logic [13:0] exp_q[$];

  asmd_result_collector dut (
    .clock(clock), .reset_b(reset_b), .Start(Start), .A(A), .E(E), .F(F),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .fifo_count(fifo_count), .overflow(overflow), .clr_ovf(clr_ovf)
  );

  always #5 clock = ~clock;

  function automatic logic [13:0] rec(input bit to, input bit e, input logic [3:0] a, input int cyc);
    return {to, e, a, 8'(cyc)};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Start sampled on edge 0, F rise sampled on edge len.
  task automatic run(input int len, input logic [3:0] a, input logic e,
                     input bit expect_push, input bit pop_on_rise);
    Start = 1'b1; F = 1'b0;
    tick();
    Start = 1'b0;
    repeat (len - 1) tick();
    A = a; E = e; F = 1'b1;
    if (pop_on_rise) out_ready = 1'b1;
    if (expect_push) exp_q.push_back(rec(1'b0, e, a, (len > 255) ? 255 : len));
    tick();
    F = 1'b0;
    if (pop_on_rise) out_ready = 1'b0;
  endtask

  always @(negedge clock) begin
    if (reset_b && out_valid && out_ready) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_record: got %h expected none", out_data);
      end else begin
        logic [13:0] e;
        e = exp_q.pop_front();
        if (out_data !== e) begin
          n_fail++;
          $display("FAIL record: got %h expected %h", out_data, e);
        end
      end
    end
  end

  initial begin
    #3;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_data", 32'(out_data), 0);
    chk("rst_count", 32'(fifo_count), 0);
    chk("rst_ovf", 32'(overflow), 0);
    tick();
    reset_b = 1'b1;
    tick();

    // basic run: 14 cycles, A=12, E=1
    out_ready = 1'b1;
    run(14, 4'b1100, 1'b1, 1'b1, 1'b0);
    chk("basic_valid_hi", 32'(out_valid), 1);
    chk("basic_count", 32'(fifo_count), 1);
    tick();
    chk("basic_valid_lo", 32'(out_valid), 0);

    // backpressure: fifth record dropped
    out_ready = 1'b0;
    run(3, 4'd1, 1'b0, 1'b1, 1'b0);
    run(4, 4'd2, 1'b1, 1'b1, 1'b0);
    run(5, 4'd3, 1'b0, 1'b1, 1'b0);
    run(6, 4'd4, 1'b1, 1'b1, 1'b0);
    chk("full_no_ovf", 32'(overflow), 0);
    run(7, 4'd5, 1'b0, 1'b0, 1'b0);
    chk("full_count", 32'(fifo_count), 4);
    chk("full_ovf", 32'(overflow), 1);
    out_ready = 1'b1;
    repeat (4) tick();
    chk("drain_count", 32'(fifo_count), 0);
    chk("ovf_sticky", 32'(overflow), 1);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    chk("ovf_cleared", 32'(overflow), 0);

    // push and pop together while full
    out_ready = 1'b0;
    run(2, 4'd6, 1'b1, 1'b1, 1'b0);
    run(3, 4'd7, 1'b0, 1'b1, 1'b0);
    run(4, 4'd8, 1'b1, 1'b1, 1'b0);
    run(5, 4'd9, 1'b0, 1'b1, 1'b0);
    run(6, 4'd10, 1'b1, 1'b1, 1'b1);
    chk("pushpop_count", 32'(fifo_count), 4);
    chk("pushpop_ovf", 32'(overflow), 0);
    out_ready = 1'b1;
    repeat (4) tick();
    chk("pushpop_drain", 32'(fifo_count), 0);

    // restart at edge 5, rise at edge 9 -> 4 cycles
    Start = 1'b1; tick();
    Start = 1'b0; repeat (4) tick();
    Start = 1'b1; tick();
    Start = 1'b0; repeat (3) tick();
    A = 4'd11; E = 1'b1; F = 1'b1;
    exp_q.push_back(rec(1'b0, 1'b1, 4'd11, 4));
    tick();
    F = 1'b0;
    tick();
    chk("restart_count", 32'(fifo_count), 0);

    // F rise in IDLE is ignored
    F = 1'b1; repeat (2) tick();
    F = 1'b0; repeat (2) tick();
    chk("idle_f_count", 32'(fifo_count), 0);
    chk("idle_f_valid", 32'(out_valid), 0);

    // Start together with F rise: restart wins, later rise 3 edges on
    Start = 1'b1; tick();
    Start = 1'b0; repeat (2) tick();
    Start = 1'b1; F = 1'b1; tick();
    Start = 1'b0; F = 1'b0; repeat (2) tick();
    A = 4'd13; E = 1'b0; F = 1'b1;
    exp_q.push_back(rec(1'b0, 1'b0, 4'd13, 3));
    tick();
    F = 1'b0;
    tick();
    chk("start_wins_count", 32'(fifo_count), 0);

`ifdef ASMD_TIMEOUT_EN
    // timeout after 199 edges, later F rise ignored
    A = 4'd5; E = 1'b0;
    Start = 1'b1; tick();
    Start = 1'b0; repeat (198) tick();
    exp_q.push_back(rec(1'b1, 1'b0, 4'd5, 199));
    tick();
    chk("timeout_valid", 32'(out_valid), 1);
    repeat (5) tick();
    F = 1'b1; repeat (2) tick();
    F = 1'b0; tick();
    chk("timeout_late_f", 32'(fifo_count), 0);
`else
    // long run saturates the counter
    run(300, 4'd5, 1'b0, 1'b1, 1'b0);
    chk("sat_valid", 32'(out_valid), 1);
    tick();
    chk("sat_count", 32'(fifo_count), 0);
`endif

    // reset mid-run with two records queued
    out_ready = 1'b0;
    run(3, 4'd14, 1'b1, 1'b0, 1'b0);
    run(4, 4'd15, 1'b0, 1'b0, 1'b0);
    chk("pre_rst_count", 32'(fifo_count), 2);
    Start = 1'b1; tick();
    Start = 1'b0; repeat (3) tick();
    reset_b = 1'b0;
    #1;
    chk("midrst_valid", 32'(out_valid), 0);
    chk("midrst_count", 32'(fifo_count), 0);
    chk("midrst_data", 32'(out_data), 0);
    tick();
    reset_b = 1'b1;
    tick();
    out_ready = 1'b1;
    run(6, 4'd9, 1'b1, 1'b1, 1'b0);
    tick();
    chk("post_rst_count", 32'(fifo_count), 0);

    repeat (3) tick();
    chk("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/asmd_result_collector.md
Name: asmd_result_collector

Overview:
- Downstream consumer of the A/E/F controller-datapath example.
- Watches the same Start pulse and the example's A[3:0], E and F outputs, and measures each run's length in clocks.
- On completion (rising edge of F), captures a result record {timeout, E, A, cycles} into a small FIFO.
- Records are presented to a software/bus consumer over a valid/ready interface.

Parameters:
- DEPTH, 4, FIFO entries; power of 2, minimum 2.
- CNT_W, 8, width of the run-length cycle counter.
- TIMEOUT_CYC, 200, cycle limit for a run; used only with ASMD_TIMEOUT_EN.

Ports:
- clock  input  1  rising-edge clock; same clock as the example design.
- reset_b  input  1  asynchronous active-low reset.
- Start  input  1  run start pulse; the same net that drives the example design.
- A  input  4  counter value from the example datapath.
- E  input  1  E flag from the example datapath.
- F  input  1  F (done) flag from the example datapath.
- out_valid  output  1  head record available.
- out_ready  input  1  consumer accepts the head record.
- out_data  output  CNT_W+6  record: [CNT_W+5] timeout, [CNT_W+4] E, [CNT_W+3:CNT_W] A, [CNT_W-1:0] cycles.
- fifo_count  output  log2(DEPTH)+1  entries currently held.
- overflow  output  1  sticky: a record was dropped because the FIFO was full.
- clr_ovf  input  1  synchronous clear of overflow.

Behaviour:
- Reset (async, reset_b=0):
  - state=IDLE, counter=0, F_d=0, FIFO empty.
  - out_valid=0, out_data=0, fifo_count=0, overflow=0.
- F edge detection: registered copy F_d; f_rise = F & ~F_d.
- FSM states IDLE, RUN:
  - IDLE → RUN when Start=1; counter loads 0.
  - RUN: counter increments by 1 each cycle; saturates at 2^CNT_W-1 (no wrap).
  - RUN with f_rise → push record {0, E, A, counter}, go to IDLE.
  - Start=1 while in RUN → restart: counter loads 0, stay RUN, no record pushed.
  - Start and f_rise in the same RUN cycle → Start wins: restart, no push.
  - f_rise in IDLE → ignored, no push.
- Captured values: E and A as sampled on the same edge that samples f_rise. Cycles = number of edges from the edge sampling Start to the edge sampling f_rise.
- FIFO handshake:
  - Transfer occurs when out_valid & out_ready.
  - out_data is stable while out_valid=1 and not accepted.
  - First-word fall-through: a record pushed at edge k gives out_valid=1 after edge k.
- FIFO boundaries:
  - Push when full without a simultaneous pop → record dropped, overflow set.
  - Push and pop in the same cycle when full → both succeed; count unchanged.
  - Pop when empty → no effect.
- overflow: clr_ovf clears it; if clr_ovf and a new drop occur in the same cycle, the set wins.
- fifo_count: never exceeds DEPTH; wrap-around of the read/write pointers is transparent.
- Reset asserted mid-run or with FIFO contents: all state and records are discarded immediately.

Optional Feature:
- ASMD_TIMEOUT_EN defined:
  - In RUN, when counter reaches TIMEOUT_CYC-1 without f_rise, push {1, E, A, counter} and go to IDLE.
  - Timeout takes precedence over a simultaneous f_rise; Start still wins over both.
- ASMD_TIMEOUT_EN undefined:
  - No timeout logic; RUN persists until f_rise or Start.
  - Record bit CNT_W+5 is constant 0.

Decomposition:
- Package asmd_collect_pkg holds:
  - FSM state encoding (IDLE=0, RUN=1).
  - Record field offset localparams (TO_BIT, E_BIT, A_LSB, CYC_LSB).
  - Record width function of CNT_W.
- One sub-module: result_fifo. Synchronous FWFT FIFO parameterised by WIDTH and DEPTH, with push/full/pop/empty/count. The collector owns the FSM, counter, edge detect and overflow flag.

Test Plan:
- Basic run: Start at edge 0, drive A=4'b1100, E=1, F rise sampled at edge 14, out_ready=1 → single record timeout=0, E=1, A=12, cycles=14; out_valid high one cycle.
- Backpressure/full: out_ready=0, DEPTH=4, five complete runs → fifo_count=4, overflow=1, fifth record lost. Raise out_ready → four records drain in order; clr_ovf → overflow=0.
- Simultaneous push/pop at full: FIFO full, out_ready=1 on the cycle a new f_rise arrives → count stays 4, no overflow, ordering preserved.
- Restart and F-in-IDLE: Start at edge 0, Start again at edge 5, f_rise at edge 9 → one record with cycles=4. f_rise with no Start → no record.
- Saturation/reset: CNT_W=4, run of 30 cycles → cycles=15. Assert reset_b=0 mid-run with 2 records queued → out_valid=0, fifo_count=0 immediately.
- ASMD_TIMEOUT_EN, TIMEOUT_CYC=20: Start, F held low → record timeout=1, cycles=19 pushed 19 edges after Start; later f_rise in IDLE is ignored.
